// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath width, ALU opcodes, branch condition codes.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_type;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// 32-bit integer ALU; unused opcodes produce 0.
module alu
   import riscv_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_type  op,
   output logic [31:0] y
);

   always_comb begin
      y = '0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SLL:  y = a << b[4:0];
         ALU_SRL:  y = a >> b[4:0];
         ALU_SRA:  y = 32'($signed(a) >>> b[4:0]);
         ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: y = {31'b0, a < b};
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/branch_cmp.sv
// Conditional-branch evaluator on already-forwarded register values.
module branch_cmp
   import riscv_pkg::*;
(
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [2:0]  funct3,
   output logic        taken
);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = (rs1 == rs2);
         F3_BNE:  taken = (rs1 != rs2);
         F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
         F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
         F3_BLTU: taken = (rs1 <  rs2);
         F3_BGEU: taken = (rs1 >= rs2);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
module ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [XLEN-1:0] id_pc,
   input  logic [4:0]      id_rs1_addr,
   input  logic [4:0]      id_rs2_addr,
   input  logic [4:0]      id_rd_addr,
   input  logic [XLEN-1:0] id_rs1_val,
   input  logic [XLEN-1:0] id_rs2_val,
   input  logic [XLEN-1:0] id_imm,
   input  logic [3:0]      id_alu_op,
   input  logic            id_src_a_pc,
   input  logic            id_src_b_imm,
   input  logic            id_reg_write,
   input  logic            id_branch,
   input  logic [2:0]      id_funct3,
   input  logic            id_jump,
   input  logic            id_jalr,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_result,
   output logic [XLEN-1:0] ex_store_data,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_write,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);
   import riscv_pkg::*;

   logic [XLEN-1:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_y, result, target, jalr_sum;
   logic            cond, redirect_req, accept;

   // EX/MEM is younger than WB, so it is checked first; ex_reg_write already excludes x0.
   function automatic logic [XLEN-1:0] fwd(input logic [4:0] addr, input logic [XLEN-1:0] rf_val,
                                           input logic ev, input logic ew, input logic [4:0] erd,
                                           input logic [XLEN-1:0] eres, input logic we,
                                           input logic [4:0] wrd, input logic [XLEN-1:0] wdat);
      if (addr == 5'd0)                      return '0;
      else if (ev && ew && erd == addr)      return eres;
      else if (we && wrd == addr)            return wdat;
      else                                   return rf_val;
   endfunction

   always_comb begin
      rs1_fwd = fwd(id_rs1_addr, id_rs1_val, ex_valid, ex_reg_write, ex_rd, ex_result,
                    wb_we, wb_rd, wb_data);
      rs2_fwd = fwd(id_rs2_addr, id_rs2_val, ex_valid, ex_reg_write, ex_rd, ex_result,
                    wb_we, wb_rd, wb_data);
   end

   assign op_a = id_src_a_pc  ? id_pc  : rs1_fwd;
   assign op_b = id_src_b_imm ? id_imm : rs2_fwd;

   alu u_alu (
      .a  (op_a),
      .b  (op_b),
      .op (alu_op_type'(id_alu_op)),
      .y  (alu_y)
   );

   branch_cmp u_branch_cmp (
      .rs1    (rs1_fwd),
      .rs2    (rs2_fwd),
      .funct3 (id_funct3),
      .taken  (cond)
   );

   assign result       = id_jump ? id_pc + 32'd4 : alu_y;
   assign jalr_sum     = rs1_fwd + id_imm;
   assign target       = (id_jump && id_jalr) ? {jalr_sum[XLEN-1:1], 1'b0} : id_pc + id_imm;
   assign redirect_req = id_jump || (id_branch && cond);

   // While a redirect is outstanding the presented instruction is wrong-path: take it and drop it.
   assign id_ready = !ex_valid || ex_ready || redirect_valid;
   assign accept   = id_valid && id_ready && !redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid       <= 1'b0;
         ex_result      <= '0;
         ex_store_data  <= '0;
         ex_rd          <= '0;
         ex_reg_write   <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= 1'b0;
         if (accept) begin
            ex_valid       <= 1'b1;
            ex_result      <= result;
            ex_store_data  <= rs2_fwd;
            ex_rd          <= id_rd_addr;
            ex_reg_write   <= id_reg_write && (id_rd_addr != 5'd0);
            redirect_valid <= redirect_req;
            redirect_pc    <= target;
         end else if (ex_valid && ex_ready) begin
            ex_valid <= 1'b0;
         end
      end
   end

endmodule
